replica_exchange_test: RTL and testbench

Per-replica Metropolis exchange tester for the replica-exchange salesman core. On each exchange round, the lower-id replica of every active pair compares its own tour energy with its follower's. It draws a uniform random number from a local xorshift32 generator and decides whether the pair swaps. The one-bit decision drives the partner `replica_d` exchange-result inputs (`prev_exchange` / `folw_exchange`). The result is valid and held before `exchange_run` fires.

---
 rtl/replica_pkg.sv | 33 +++
 rtl/replica_exchange_test_neg_log_u.sv | 45 ++++
 rtl/replica_exchange_test.sv | 117 +++++++++++
 tb/tb_replica_exchange_test.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/replica_pkg.sv
// Shared types and constants for the replica-exchange salesman core:
// command encoding, exchange-tester state, fixed-point constants and the RNG step.
package replica_pkg;

  localparam int          ENERGY_W   = 24;
  localparam logic [15:0] LN2_Q16    = 16'd45426;
  localparam int          DBETA_FRAC = 8;

  typedef enum logic {
    OR0 = 1'b0,
    OR1 = 1'b1
  } command_t;

  typedef struct packed {
    command_t command;
  } opt_t;

  typedef enum logic [1:0] {
    XT_IDLE,
    XT_LATCH,
    XT_MUL,
    XT_CMP
  } xt_state_t;

  function automatic logic [31:0] xorshift32(input logic [31:0] s);
    logic [31:0] v;
    v = s ^ (s << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

endpackage

// File: rtl/replica_exchange_test_neg_log_u.sv
// Registered approximation of -ln(u/2^32) in unsigned Q8.8 using a
// leading-zero count plus 8 mantissa bits, scaled from log2 to ln.
module neg_log_u
  import replica_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] u,
  output logic [15:0] l
);

  logic [5:0]  lz;
  logic [7:0]  m;
  logic [38:0] u_ext;
  logic [15:0] nlog2;
  logic [31:0] prod;

  // u_ext[i +: 8] lines up the 8 bits just below bit i of u
  assign u_ext = {u[30:0], 8'h00};

  always_comb begin
    lz = 6'd32;
    m  = 8'h00;
    for (int i = 0; i < 32; i++) begin
      if (u[i]) begin
        lz = 6'(31 - i);
        m  = u_ext[i +: 8];
      end
    end
  end

  assign nlog2 = (({10'd0, lz} + 16'd1) << 8) - {8'd0, m};
  assign prod  = {16'd0, nlog2} * {16'd0, LN2_Q16};

  always_ff @(posedge clk) begin
    if (!reset) begin
      l <= '0;
    end else if (u == '0) begin
      l <= 16'hFFFF;
    end else begin
      l <= 16'(prod >> 16);
    end
  end

endmodule

// File: rtl/replica_exchange_test.sv
// Metropolis exchange tester: latches energies and a random draw, forms
// d_beta*(E_folw-E_self) and compares it against -ln(u) to decide a swap.
module replica_exchange_test
  import replica_pkg::*;
#(
  parameter int          id          = 0,
  parameter int          replica_num = 32,
  parameter int          ENERGY_W    = replica_pkg::ENERGY_W,
  parameter logic [31:0] SEED        = 32'h2545_F491
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                test_start,
  input  opt_t                opt,
  input  logic [ENERGY_W-1:0] self_energy,
  input  logic [ENERGY_W-1:0] folw_energy,
  input  logic [15:0]         d_beta,
  input  logic                seed_we,
  input  logic [31:0]         seed,
  output logic                busy,
  output logic                test_done,
  output logic                out_exchange
);

  localparam int          XW         = ENERGY_W + 9 + DBETA_FRAC;
  localparam logic [31:0] RNG_INIT   = SEED ^ 32'(id);
  localparam logic        TESTER_OR0 = ((id % 2) == 0) && (id < replica_num - 1);
  localparam logic        TESTER_OR1 = ((id % 2) == 1) && (id < replica_num - 1);

  xt_state_t state;
  logic [31:0] rng;
  logic        start_ok;

  logic signed [ENERGY_W:0] x_e_p0;
  logic [31:0]              u_p0;
  logic [15:0]              d_beta_p0;
  logic                     tester_p0;

  logic signed [XW-1:0] xe_ext;
  logic signed [XW-1:0] db_ext;
  logic signed [XW-1:0] x_p1;
  logic [15:0]          l_p1;

  logic signed [XW:0] sum;
  logic               accept;

  // CMP also accepts a start so back-to-back tests chain on the done cycle
  assign start_ok = test_start && ((state == XT_IDLE) || (state == XT_CMP));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= XT_IDLE;
      busy         <= 1'b0;
      test_done    <= 1'b0;
      out_exchange <= 1'b0;
    end else begin
      test_done <= 1'b0;
      case (state)
        XT_IDLE, XT_CMP: begin
          if (test_start) begin
            state <= XT_LATCH;
            busy  <= 1'b1;
          end else begin
            state <= XT_IDLE;
            busy  <= 1'b0;
          end
        end
        XT_LATCH: state <= XT_MUL;
        XT_MUL: begin
          state        <= XT_CMP;
          test_done    <= 1'b1;
          out_exchange <= accept & tester_p0;
        end
        default: state <= XT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rng <= RNG_INIT;
    end else if (seed_we && (seed != '0)) begin
      rng <= seed;
    end else if (start_ok) begin
      rng <= xorshift32(rng);
    end
  end

  // Stage p0: operands captured on an accepted start
  always_ff @(posedge clk) begin
    if (start_ok) begin
      x_e_p0    <= {1'b0, folw_energy} - {1'b0, self_energy};
      u_p0      <= rng;
      d_beta_p0 <= d_beta;
      tester_p0 <= (opt.command == OR0) ? TESTER_OR0 : TESTER_OR1;
    end
  end

  assign xe_ext = {{(XW - ENERGY_W - 1){x_e_p0[ENERGY_W]}}, x_e_p0};
  assign db_ext = {{(XW - 16){1'b0}}, d_beta_p0};

  // Stage p1: scaled energy difference and -ln(u), both Q.8
  always_ff @(posedge clk) begin
    x_p1 <= xe_ext * db_ext;
  end

  neg_log_u u_neg_log (
    .clk   (clk),
    .reset (reset),
    .u     (u_p0),
    .l     (l_p1)
  );

  assign sum    = {x_p1[XW-1], x_p1} + {{(XW - 15){1'b0}}, l_p1};
  assign accept = !x_p1[XW-1] || (!sum[XW] && (sum != '0));

endmodule

// File: tb/tb_replica_exchange_test.sv
// Bench for replica_exchange_test: three replicas (ids 0, 1, 31) share stimulus
// and are checked against a plain-arithmetic Metropolis model.
module tb_replica_exchange_test;
  import replica_pkg::*;

  logic        clk;
  logic        reset;
  logic        test_start;
  opt_t        opt;
  logic [23:0] self_energy;
  logic [23:0] folw_energy;
  logic [15:0] d_beta;
  logic        seed_we;
  logic [31:0] seed;
  logic        busy_o [3];
  logic        done_o [3];
  logic        ex_o   [3];

  int checks;
  int failures;

  logic [31:0] m_rng [3];
  bit          m_exp [3];

  localparam logic [31:0] SEED_DEF = 32'h2545_F491;

  replica_exchange_test #(.id(0), .replica_num(32)) u_r0 (
    .clk(clk), .reset(reset), .test_start(test_start), .opt(opt),
    .self_energy(self_energy), .folw_energy(folw_energy), .d_beta(d_beta),
    .seed_we(seed_we), .seed(seed),
    .busy(busy_o[0]), .test_done(done_o[0]), .out_exchange(ex_o[0]));

  replica_exchange_test #(.id(1), .replica_num(32)) u_r1 (
    .clk(clk), .reset(reset), .test_start(test_start), .opt(opt),
    .self_energy(self_energy), .folw_energy(folw_energy), .d_beta(d_beta),
    .seed_we(seed_we), .seed(seed),
    .busy(busy_o[1]), .test_done(done_o[1]), .out_exchange(ex_o[1]));

  replica_exchange_test #(.id(31), .replica_num(32)) u_r31 (
    .clk(clk), .reset(reset), .test_start(test_start), .opt(opt),
    .self_energy(self_energy), .folw_energy(folw_energy), .d_beta(d_beta),
    .seed_we(seed_we), .seed(seed),
    .busy(busy_o[2]), .test_done(done_o[2]), .out_exchange(ex_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int id_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 31);
  endfunction

  function automatic logic [31:0] m_xs(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // -ln(u/2^32) in Q8.8 via msb position and the next 8 bits
  function automatic longint m_negln(input logic [31:0] u);
    int p;
    int lz;
    logic [63:0] w;
    longint mant;
    longint nl2;
    if (u == 32'd0) return 65535;
    p = 0;
    for (int i = 0; i < 32; i++) if (u[i]) p = i;
    lz = 31 - p;
    w = 64'(u) << (lz + 1);
    mant = longint'(w[31:24]);
    nl2 = longint'(lz + 1) * 256 - mant;
    return (nl2 * 45426) / 65536;
  endfunction

  function automatic bit m_decide(input int k, input bit cmd, input int s, input int f,
                                  input int db, input logic [31:0] u);
    bit tester;
    longint x;
    longint l;
    int rid;
    rid = id_of(k);
    tester = ((cmd == 1'b0) ? (rid % 2 == 0) : (rid % 2 == 1)) && (rid < 31);
    x = longint'(f - s) * longint'(db);
    l = m_negln(u);
    return tester && ((x >= 0) || (x + l > 0));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_test(input bit cmd, input int s, input int f, input int db);
    opt.command = cmd ? OR1 : OR0;
    self_energy = 24'(s);
    folw_energy = 24'(f);
    d_beta      = 16'(db);
    test_start  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_exp[k] = m_decide(k, cmd, s, f, db, m_rng[k]);
      m_rng[k] = m_xs(m_rng[k]);
    end
    tick();
    test_start = 1'b0;
  endtask

  task automatic load_seed(input logic [31:0] v);
    seed    = v;
    seed_we = 1'b1;
    if (v != 32'd0) for (int k = 0; k < 3; k++) m_rng[k] = v;
    tick();
    seed_we = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_rng[k] = SEED_DEF ^ 32'(id_of(k));
      m_exp[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    model_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy_o[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_busy dut%0d got=%b want=0", k, busy_o[k]);
      end
      checks++;
      if (done_o[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_done dut%0d got=%b want=0", k, done_o[k]);
      end
      checks++;
      if (ex_o[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_ex dut%0d got=%b want=0", k, ex_o[k]);
      end
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] v_seed [6] = '{32'd0, 32'h8000_0000, 32'h0000_0001, 32'd0, 32'd0, 32'd0};
    bit          v_cmd  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          v_self [6] = '{1000, 1010, 1010, 1000, 5000, 777};
    int          v_folw [6] = '{1010, 1000, 1000, 1010, 10, 777};
    int          v_db   [6] = '{256, 256, 256, 256, 0, 65535};
    bit          v_want [6][3] = '{'{1, 0, 0}, '{0, 0, 0}, '{1, 0, 0},
                                   '{0, 1, 0}, '{1, 0, 0}, '{0, 1, 0}};
    for (int n = 0; n < 6; n++) begin
      if (v_seed[n] != 32'd0) load_seed(v_seed[n]);
      start_test(v_cmd[n], v_self[n], v_folw[n], v_db[n]);
      checks++;
      if (busy_o[0] !== 1'b1 || done_o[0] !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_t1 busy=%b done=%b want busy=1 done=0", n, busy_o[0], done_o[0]);
      end
      tick();
      checks++;
      if (done_o[0] !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_t2_done got=%b want=0", n, done_o[0]);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (done_o[k] !== 1'b1 || ex_o[k] !== v_want[n][k]) begin
          failures++;
          $display("FAIL dir%0d_t3 dut%0d done=%b ex=%b want done=1 ex=%b",
                   n, k, done_o[k], ex_o[k], v_want[n][k]);
        end
      end
      tick();
      checks++;
      if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_t4 done=%b busy=%b want 0 0", n, done_o[0], busy_o[0]);
      end
    end
  endtask

  task automatic test_busy_start();
    start_test(1'b0, 1000, 1010, 256);
    opt.command = OR0;
    self_energy = 24'd1010;
    folw_energy = 24'd0;
    d_beta      = 16'hFFFF;
    test_start  = 1'b1;
    tick();
    test_start = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (done_o[k] !== 1'b1 || ex_o[k] !== m_exp[k]) begin
        failures++;
        $display("FAIL busy_start_t3 dut%0d done=%b ex=%b want done=1 ex=%b",
                 k, done_o[k], ex_o[k], m_exp[k]);
      end
    end
    tick();
    checks++;
    if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_t4 done=%b busy=%b want 0 0", done_o[0], busy_o[0]);
    end
    tick();
    checks++;
    if (done_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_t5_done got=%b want=0", done_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    start_test(1'b0, 1000, 1010, 256);
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (done_o[k] !== 1'b1 || ex_o[k] !== m_exp[k]) begin
        failures++;
        $display("FAIL b2b_first dut%0d done=%b ex=%b want done=1 ex=%b",
                 k, done_o[k], ex_o[k], m_exp[k]);
      end
    end
    start_test(1'b1, 1010, 0, 65535);
    checks++;
    if (busy_o[0] !== 1'b1 || done_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_t4 busy=%b done=%b want busy=1 done=0", busy_o[0], done_o[0]);
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (done_o[k] !== 1'b1 || ex_o[k] !== m_exp[k]) begin
        failures++;
        $display("FAIL b2b_second dut%0d done=%b ex=%b want done=1 ex=%b",
                 k, done_o[k], ex_o[k], m_exp[k]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    int s;
    int f;
    int db;
    bit cmd;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) load_seed(($urandom_range(0, 2) == 0) ? 32'd0 : $urandom);
      cmd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        s  = int'($urandom_range(0, 24'hFF_FFFF));
        f  = int'($urandom_range(0, 24'hFF_FFFF));
        db = int'($urandom_range(0, 16'hFFFF));
      end else begin
        s  = int'($urandom_range(16, 24'hFF_FF00));
        f  = s + int'($urandom_range(0, 16)) - 8;
        db = int'($urandom_range(0, 16'h03FF));
      end
      start_test(cmd, s, f, db);
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (done_o[k] !== 1'b1 || ex_o[k] !== m_exp[k]) begin
          failures++;
          $display("FAIL rand%0d dut%0d done=%b ex=%b want done=1 ex=%b (s=%0d f=%0d db=%0d)",
                   n, k, done_o[k], ex_o[k], m_exp[k], s, f, db);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    start_test(1'b0, 1000, 1010, 256);
    tick();
    reset = 1'b0;
    tick();
    model_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (done_o[k] !== 1'b0 || busy_o[k] !== 1'b0 || ex_o[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid dut%0d done=%b busy=%b ex=%b want 0 0 0",
                 k, done_o[k], busy_o[k], ex_o[k]);
      end
    end
    reset = 1'b1;
    tick();
    start_test(1'b0, 1002, 1000, 250);
    tick();
    tick();
    checks++;
    if (ex_o[0] !== 1'b1 || done_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_reseed ex=%b done=%b want ex=1 done=1", ex_o[0], done_o[0]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ex_o[k] !== m_exp[k]) begin
        failures++;
        $display("FAIL reset_reseed_model dut%0d got=%b want=%b", k, ex_o[k], m_exp[k]);
      end
    end
    tick();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    test_start  = 1'b0;
    opt.command = OR0;
    self_energy = '0;
    folw_energy = '0;
    d_beta      = '0;
    seed_we     = 1'b0;
    seed        = '0;
    #1;
    test_reset();
    test_directed();
    test_busy_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
